pipe_stage_reg: RTL and testbench

Parametrised pipeline stage register, the successor to the fixed 32-bit PC register. It carries a WIDTH-bit payload between RISC-V pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB) using a valid/ready handshake, an optional skid buffer, and a flush input for branch and exception squash. It accepts one beat per cycle with one cycle of latency, and keeps full throughput under backpressure when the skid buffer is enabled.

---
 rtl/riscv_pipe_pkg.sv | 16 +
 rtl/pipe_stage_reg.sv | 124 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/riscv_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_pipe_pkg
// Brief    : Shared pipeline-stage constants (state encoding, default XLEN).
// Revision : 1.0 - initial release
// ============================================================================
package riscv_pipe_pkg;

   localparam int XLEN = 32;

   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_BUSY  = 2'd1;
   localparam logic [1:0] ST_FULL  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_reg
// Brief    : Valid/ready pipeline stage register with optional skid buffer and flush.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_reg
   import riscv_pipe_pkg::*;
#(
   parameter int               WIDTH     = XLEN,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   parameter int               SKID      = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       occupancy
);

   logic [1:0]       r_state;
   logic [1:0]       w_state_nxt;
   logic             r_out_valid;
   logic [WIDTH-1:0] r_main;
   logic [WIDTH-1:0] w_skid_q;
   logic             w_in_xfer;
   logic             w_out_xfer;
   logic             w_main_ld;
   logic             w_main_from_skid;
   logic             w_skid_ld;

   assign w_in_xfer  = in_valid && in_ready;
   assign w_out_xfer = r_out_valid && out_ready;

   always_comb begin
      w_state_nxt      = r_state;
      w_main_ld        = 1'b0;
      w_main_from_skid = 1'b0;
      w_skid_ld        = 1'b0;
      case (r_state)
         ST_EMPTY: begin
            if (w_in_xfer) begin
               w_main_ld   = 1'b1;
               w_state_nxt = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (w_in_xfer && w_out_xfer) begin
               w_main_ld = 1'b1;
            end else if (w_in_xfer) begin
               w_skid_ld   = 1'b1;
               w_state_nxt = ST_FULL;
            end else if (w_out_xfer) begin
               w_state_nxt = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (out_ready) begin
               w_main_ld        = 1'b1;
               w_main_from_skid = 1'b1;
               w_state_nxt      = ST_BUSY;
            end
         end
         default: w_state_nxt = ST_EMPTY;
      endcase
      // Flush only clears validity; payload registers are left untouched.
      if (flush) begin
         w_state_nxt      = ST_EMPTY;
         w_main_ld        = 1'b0;
         w_main_from_skid = 1'b0;
         w_skid_ld        = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= ST_EMPTY;
         r_out_valid <= 1'b0;
         r_main      <= RESET_VAL;
      end else begin
         r_state     <= w_state_nxt;
         r_out_valid <= (w_state_nxt != ST_EMPTY);
         if (w_main_ld) begin
            r_main <= w_main_from_skid ? w_skid_q : in_data;
         end
      end
   end

   generate
      if (SKID != 0) begin : g_skid
         logic [WIDTH-1:0] r_skid;
         logic             r_in_ready;

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               r_skid     <= RESET_VAL;
               r_in_ready <= 1'b1;
            end else begin
               r_in_ready <= (w_state_nxt != ST_FULL);
               if (w_skid_ld) begin
                  r_skid <= in_data;
               end
            end
         end

         assign w_skid_q = r_skid;
         assign in_ready = r_in_ready;
      end else begin : g_noskid
         assign w_skid_q = RESET_VAL;
         assign in_ready = !r_out_valid || out_ready;
      end
   endgenerate

   assign out_valid = r_out_valid;
   assign out_data  = r_main;
   assign occupancy = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_reg
// Brief    : Scoreboard bench for pipe_stage_reg (SKID=1 32-bit, SKID=0 8-bit).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

   localparam logic [31:0] c_rst_a = 32'hDEAD_BEEF;
   localparam logic [7:0]  c_rst_b = 8'h3C;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [31:0] in_data, out_data;
   logic [1:0]  occupancy;

   logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
   logic [7:0]  b_in_data, b_out_data;
   logic [1:0]  b_occupancy;

   int          n_pass = 0;
   int          n_total = 0;
   int          n_out = 0;
   int          cyc = 0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   pipe_stage_reg #(.WIDTH(32), .RESET_VAL(c_rst_a), .SKID(1)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .occupancy(occupancy)
   );

   pipe_stage_reg #(.WIDTH(8), .RESET_VAL(c_rst_b), .SKID(0)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
      .occupancy(b_occupancy)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h required %0h", name, act, exp);
   endtask

   // Monitor: the handshake seen at the falling edge completes at the next rising edge.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         n_out++;
         n_total++;
         if (exp_q.size() == 0) begin
            $display("FAIL sb_unexpected: got %0h required no beat", out_data);
         end else if (out_data === exp_q[0]) begin
            n_pass++;
            void'(exp_q.pop_front());
         end else begin
            $display("FAIL sb_data: got %0h required %0h", out_data, exp_q[0]);
            void'(exp_q.pop_front());
         end
      end
   end

   task automatic send(input logic [31:0] d);
      bit ok = 1'b0;
      in_valid = 1'b1;
      in_data  = d;
      for (int t = 0; t < 50; t++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (ok) begin
         if (!flush) exp_q.push_back(d);
      end else begin
         n_total++;
         $display("FAIL send_timeout: got in_ready=0 required accept of %0h", d);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int t = 0; t < 50 && exp_q.size() != 0; t++) @(negedge clk);
      chk("drain_left", 64'(exp_q.size()), 64'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1);
   end

   initial begin
      int t0;
      int n0;
      bit done;
      rst_n = 1'b0; flush = 1'b0;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
      b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b1;

      @(posedge clk); #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_data", 64'(out_data), 64'(c_rst_a));
      chk("rst_occupancy", 64'(occupancy), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_b_out_data", 64'(b_out_data), 64'(c_rst_b));
      chk("rst_b_in_ready", 64'(b_in_ready), 64'd1);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Streaming with one cycle latency.
      send(32'h1);
      chk("lat_out_valid", 64'(out_valid), 64'd1);
      chk("lat_out_data", 64'(out_data), 64'h1);
      for (int i = 2; i <= 8; i++) send(32'(i));
      drain();

      // Backpressure: out_ready low for three edges.
      out_ready = 1'b0;
      fork
         for (int i = 0; i < 6; i++) send(32'hA0 + 32'(i));
         begin
            @(posedge clk); #2;
            chk("bp_occ1", 64'(occupancy), 64'd1);
            @(posedge clk); #2;
            chk("bp_occ2", 64'(occupancy), 64'd2);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            @(posedge clk); #2;
            out_ready = 1'b1;
         end
      join
      drain();

      // Alternating out_ready with continuous input.
      n0 = n_out; t0 = cyc; done = 1'b0; out_ready = 1'b0;
      fork
         begin
            for (int i = 0; i < 100; i++) send(32'h1000 + 32'(i));
            done = 1'b1;
         end
         while (!done) begin
            @(posedge clk); #1;
            if (!done) out_ready = ~out_ready;
         end
      join
      out_ready = 1'b1;
      drain();
      chk("alt_beats", 64'(n_out - n0), 64'd100);
      chk("alt_rate_ok", 64'((cyc - t0) <= 210), 64'd1);

      // Flush while FULL, with a beat arriving in the flush cycle.
      out_ready = 1'b0;
      send(32'h11);
      send(32'h22);
      chk("fl_occ_full", 64'(occupancy), 64'd2);
      in_valid = 1'b1; in_data = 32'h33; flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      exp_q.delete();
      chk("fl_out_valid", 64'(out_valid), 64'd0);
      chk("fl_occ", 64'(occupancy), 64'd0);
      chk("fl_in_ready", 64'(in_ready), 64'd1);
      chk("fl_main_kept", 64'(out_data), 64'h11);
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      send(32'h44);
      drain();

      // Reset while BUSY with out_ready high.
      out_ready = 1'b0;
      send(32'h55);
      out_ready = 1'b1; rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      exp_q.delete();
      chk("rs_occ", 64'(occupancy), 64'd0);
      chk("rs_out_valid", 64'(out_valid), 64'd0);
      chk("rs_out_data", 64'(out_data), 64'(c_rst_a));
      repeat (4) @(posedge clk);
      #1;

      // SKID=0: combinational in_ready from out_ready.
      b_out_ready = 1'b0; b_in_valid = 1'b1; b_in_data = 8'h5A;
      @(posedge clk); #1;
      b_in_data = 8'hC3;
      chk("b_out_valid", 64'(b_out_valid), 64'd1);
      chk("b_out_data1", 64'(b_out_data), 64'h5A);
      chk("b_in_ready_lo", 64'(b_in_ready), 64'd0);
      b_out_ready = 1'b1;
      #1;
      chk("b_in_ready_hi", 64'(b_in_ready), 64'd1);
      @(posedge clk); #1;
      b_in_valid = 1'b0;
      chk("b_replace_data", 64'(b_out_data), 64'hC3);
      chk("b_replace_valid", 64'(b_out_valid), 64'd1);
      chk("b_occ", 64'(b_occupancy), 64'd1);
      @(posedge clk); #1;
      chk("b_drained", 64'(b_out_valid), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
